// File: rtl/vend_latch_driver.sv
// Vending control: coin credit, then dispense/change SR latch drive.
// Ports: clock/reset; coin_valid/coin_value/cancel in; disp_q/chg_q
// latch acks in; disp_/chg_ set/reset pulses, credit, change_amount,
// coin_reject, busy, fault out. All outputs registered.
module vend_latch_driver #(
  parameter int PRICE       = 15,
  parameter int MAX_CREDIT  = 40,
  parameter int CREDIT_W    = 6,
  parameter int HOLD_CYCLES = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic                cancel,
  input  logic                disp_q,
  input  logic                chg_q,
  output logic                disp_set,
  output logic                disp_reset,
  output logic                chg_set,
  output logic                chg_reset,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                coin_reject,
  output logic                busy,
  output logic                fault
);

  typedef enum logic [2:0] {
    ACCUM, D_SET, D_HOLD, D_CLR,
    C_SET, C_HOLD, C_CLR, FAULT
  } state_t;

  localparam int TMAX = (HOLD_CYCLES > ACK_TIMEOUT) ?
                        HOLD_CYCLES : ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAXC_C  = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [TW-1:0]       ACK_END = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0]       HLD_END = TW'(HOLD_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
  logic [TW-1:0]       tmr_q, tmr_d;

  logic disp_set_q, disp_set_d;
  logic disp_rst_q, disp_rst_d;
  logic chg_set_q, chg_set_d;
  logic chg_rst_q, chg_rst_d;
  logic reject_q, reject_d;
  logic busy_q, busy_d;
  logic fault_q, fault_d;

  logic [CREDIT_W:0] coin_amt;
  logic [CREDIT_W:0] sum;
  logic              coin_ok;
  logic              coin_acc;
  logic              ack_late;
  logic              hold_done;
  logic              enter_fault;

  always_comb begin
    coin_amt = '0;
    coin_ok  = 1'b1;
    case (coin_value)
      2'b00:   coin_amt = (CREDIT_W+1)'(5);
      2'b01:   coin_amt = (CREDIT_W+1)'(10);
      2'b10:   coin_amt = (CREDIT_W+1)'(25);
      default: coin_ok  = 1'b0;
    endcase
  end

  // One extra bit so the overflow test cannot wrap.
  assign sum       = {1'b0, credit_q} + coin_amt;
  // tmr_q is 0 in the pulse cycle, so expiry lands ACK_TIMEOUT
  // cycles after the pulse.
  assign ack_late  = (tmr_q == ACK_END);
  assign hold_done = (tmr_q == HLD_END);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ACCUM;
      credit_q   <= '0;
      chg_amt_q  <= '0;
      tmr_q      <= '0;
      disp_set_q <= 1'b0;
      disp_rst_q <= 1'b0;
      chg_set_q  <= 1'b0;
      chg_rst_q  <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      chg_amt_q  <= chg_amt_d;
      tmr_q      <= tmr_d;
      disp_set_q <= disp_set_d;
      disp_rst_q <= disp_rst_d;
      chg_set_q  <= chg_set_d;
      chg_rst_q  <= chg_rst_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    chg_amt_d = chg_amt_q;
    tmr_d     = tmr_q + 1'b1;
    coin_acc  = 1'b0;
    unique case (state_q)
      ACCUM: begin
        tmr_d = '0;
        // A reached price is served before cancel or a new coin.
        if (credit_q >= PRICE_C) begin
          state_d   = D_SET;
          chg_amt_d = credit_q - PRICE_C;
          credit_d  = '0;
        end else if (cancel && credit_q != '0) begin
          state_d   = C_SET;
          chg_amt_d = credit_q;
          credit_d  = '0;
        end else if (coin_valid && !cancel &&
                     coin_ok && sum <= MAXC_C) begin
          coin_acc = 1'b1;
          credit_d = sum[CREDIT_W-1:0];
        end
      end
      D_SET: begin
        if (disp_q) begin
          state_d = D_HOLD;
          tmr_d   = '0;
        end else if (ack_late) begin
          state_d = FAULT;
        end
      end
      D_HOLD: begin
        if (hold_done) begin
          state_d = D_CLR;
          tmr_d   = '0;
        end
      end
      D_CLR: begin
        if (!disp_q) begin
          tmr_d   = '0;
          state_d = (chg_amt_q != '0) ? C_SET : ACCUM;
        end else if (ack_late) begin
          state_d = FAULT;
        end
      end
      C_SET: begin
        if (chg_q) begin
          state_d = C_HOLD;
          tmr_d   = '0;
        end else if (ack_late) begin
          state_d = FAULT;
        end
      end
      C_HOLD: begin
        if (hold_done) begin
          state_d = C_CLR;
          tmr_d   = '0;
        end
      end
      C_CLR: begin
        if (!chg_q) begin
          state_d   = ACCUM;
          chg_amt_d = '0;
          tmr_d     = '0;
        end else if (ack_late) begin
          state_d = FAULT;
        end
      end
      FAULT:   tmr_d   = tmr_q;
      default: state_d = FAULT;
    endcase
  end

  // Pulses fire on entry to a command state, so each is one cycle.
  always_comb begin
    enter_fault = (state_d == FAULT) && (state_q != FAULT);
    disp_set_d  = (state_d == D_SET) && (state_q != D_SET);
    disp_rst_d  = ((state_d == D_CLR) && (state_q != D_CLR)) ||
                  enter_fault;
    chg_set_d   = (state_d == C_SET) && (state_q != C_SET);
    chg_rst_d   = ((state_d == C_CLR) && (state_q != C_CLR)) ||
                  enter_fault;
    reject_d    = coin_valid && !coin_acc;
    busy_d      = (state_d != ACCUM);
    fault_d     = (state_d == FAULT);
  end

  assign disp_set      = disp_set_q;
  assign disp_reset    = disp_rst_q;
  assign chg_set       = chg_set_q;
  assign chg_reset     = chg_rst_q;
  assign credit        = credit_q;
  assign change_amount = chg_amt_q;
  assign coin_reject   = reject_q;
  assign busy          = busy_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_vend_latch_driver.sv
// Bench for vend_latch_driver: vector table, directed sequences and
// random coins against a timeline model of the vending sequence.
module tb_vend_latch_driver;

  localparam int PRICE = 15;
  localparam int MAXC  = 40;
  localparam int H     = 4;
  localparam int N     = 4096;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid, cancel;
  logic [1:0] coin_value;
  logic       disp_q, chg_q;
  logic       disp_set, disp_reset, chg_set, chg_reset;
  logic [5:0] credit, change_amount;
  logic       coin_reject, busy, fault;
  logic       d_stuck;

  logic       cv2, cn2;
  logic [1:0] val2;
  logic       q2_zero;
  logic       o2_ds, o2_dr, o2_cs, o2_cr, o2_rej, o2_busy, o2_fault;
  logic [5:0] o2_credit, o2_chg;

  always #5 clock = ~clock;

  vend_latch_driver u_dut (
    .clock(clock), .reset(reset),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .cancel(cancel), .disp_q(disp_q), .chg_q(chg_q),
    .disp_set(disp_set), .disp_reset(disp_reset),
    .chg_set(chg_set), .chg_reset(chg_reset),
    .credit(credit), .change_amount(change_amount),
    .coin_reject(coin_reject), .busy(busy), .fault(fault)
  );

  vend_latch_driver #(.PRICE(40), .MAX_CREDIT(40)) u_dut40 (
    .clock(clock), .reset(reset),
    .coin_valid(cv2), .coin_value(val2),
    .cancel(cn2), .disp_q(q2_zero), .chg_q(q2_zero),
    .disp_set(o2_ds), .disp_reset(o2_dr),
    .chg_set(o2_cs), .chg_reset(o2_cr),
    .credit(o2_credit), .change_amount(o2_chg),
    .coin_reject(o2_rej), .busy(o2_busy), .fault(o2_fault)
  );

  // External SR latches, answering one cycle after a command.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      if (!d_stuck) begin
        if (disp_set) disp_q <= 1'b1;
        else if (disp_reset) disp_q <= 1'b0;
      end
      if (chg_set) chg_q <= 1'b1;
      else if (chg_reset) chg_q <= 1'b0;
    end
  end

  int n_cmp, n_bad, cyc, k;
  bit m_on;
  int m_credit, m_idle_from;
  bit e_ds [N];
  bit e_dr [N];
  bit e_cs [N];
  bit e_cr [N];
  bit e_busy [N];
  bit e_rej [N];
  int e_chg [N];
  int e_credit [N];

  typedef struct {
    logic       cv;
    logic [1:0] val;
    logic       cn;
    int         credit;
    logic       rej;
    logic       busy;
    logic       ds;
  } vec_t;
  vec_t tbl [7];

  function automatic int cval(input logic [1:0] v);
    case (v)
      2'b00:   return 5;
      2'b01:   return 10;
      2'b10:   return 25;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      e_ds[i] = 0; e_dr[i] = 0; e_cs[i] = 0; e_cr[i] = 0;
      e_busy[i] = 0; e_rej[i] = 0; e_chg[i] = 0; e_credit[i] = 0;
    end
    m_credit    = 0;
    m_idle_from = 0;
    cyc         = 0;
  endtask

  // One latch episode: set at t, reset at t+2+H, done at t+4+H.
  task automatic sched(input int t, input int amt, input bit disp);
    if (disp) begin
      e_ds[t] = 1; e_dr[t+2+H] = 1;
    end else begin
      e_cs[t] = 1; e_cr[t+2+H] = 1;
    end
    for (int i = t; i < t + 4 + H; i++) begin
      e_busy[i] = 1;
      e_chg[i]  = amt;
    end
    m_idle_from = t + 4 + H;
  endtask

  task automatic model_step(input logic cv, input logic [1:0] v,
                            input logic cn);
    bit idle, rej;
    int chg;
    idle = (cyc >= m_idle_from);
    rej  = 0;
    if (idle && m_credit >= PRICE) begin
      chg = m_credit - PRICE;
      sched(cyc + 1, chg, 1'b1);
      if (chg > 0) sched(cyc + 5 + H, chg, 1'b0);
      m_credit = 0;
      rej = cv;
    end else if (idle && cn && m_credit > 0) begin
      sched(cyc + 1, m_credit, 1'b0);
      m_credit = 0;
      rej = cv;
    end else if (idle && cv && !cn && v != 2'b11 &&
                 m_credit + cval(v) <= MAXC) begin
      m_credit += cval(v);
    end else begin
      rej = cv;
    end
    e_credit[cyc+1] = m_credit;
    e_rej[cyc+1]    = rej;
  endtask

  task automatic check_cycle();
    if (m_on) begin
      chk("disp_set", int'(disp_set), int'(e_ds[cyc]));
      chk("disp_reset", int'(disp_reset), int'(e_dr[cyc]));
      chk("chg_set", int'(chg_set), int'(e_cs[cyc]));
      chk("chg_reset", int'(chg_reset), int'(e_cr[cyc]));
      chk("busy", int'(busy), int'(e_busy[cyc]));
      chk("coin_reject", int'(coin_reject), int'(e_rej[cyc]));
      chk("credit", int'(credit), e_credit[cyc]);
      chk("change_amount", int'(change_amount), e_chg[cyc]);
      chk("fault", int'(fault), 0);
      chk("set_reset_excl",
          int'((disp_set & disp_reset) | (chg_set & chg_reset)), 0);
    end
  endtask

  task automatic step(input logic cv, input logic [1:0] v,
                      input logic cn);
    coin_valid = cv;
    coin_value = v;
    cancel     = cn;
    model_step(cv, v, cn);
    @(negedge clock);
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    coin_valid = 1'b0;
    coin_value = 2'b00;
    cancel     = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    check_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_on = 1'b1; d_stuck = 1'b0;
    coin_valid = 1'b0; coin_value = 2'b00; cancel = 1'b0;
    cv2 = 1'b0; val2 = 2'b00; cn2 = 1'b0; q2_zero = 1'b0;

    tbl[0] = '{1'b0, 2'b00, 1'b1,  0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'b01, 1'b1,  0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 2'b00, 1'b0,  5, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 2'b11, 1'b0,  5, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 2'b00, 1'b0,  5, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 2'b01, 1'b0, 15, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 2'b00, 1'b0,  0, 1'b1, 1'b1, 1'b1};

    do_reset();
    chk("reset_busy", int'(busy), 0);
    chk("reset_credit", int'(credit), 0);
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].cv, tbl[i].val, tbl[i].cn);
      chk("tbl_credit", int'(credit), tbl[i].credit);
      chk("tbl_reject", int'(coin_reject), int'(tbl[i].rej));
      chk("tbl_busy", int'(busy), int'(tbl[i].busy));
      chk("tbl_disp_set", int'(disp_set), int'(tbl[i].ds));
    end
    idle(20);

    // Coins 10 then 5: dispense only, 8 cycles back to ACCUM.
    do_reset();
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    chk("credit_at_price", int'(credit), 15);
    step(1'b0, 2'b00, 1'b0);
    chk("disp_set_first", int'(disp_set), 1);
    k = 0;
    while (busy && k < 30) begin
      idle(1);
      k++;
    end
    chk("disp_to_accum", k, 8);
    idle(5);

    // Coin 25: dispense then 10 change, held through C_HOLD.
    do_reset();
    step(1'b1, 2'b10, 1'b0);
    idle(1);
    chk("c25_disp_set", int'(disp_set), 1);
    idle(11);
    chk("c25_hold_change", int'(change_amount), 10);
    chk("c25_hold_busy", int'(busy), 1);
    idle(5);
    chk("c25_end_change", int'(change_amount), 0);
    chk("c25_end_busy", int'(busy), 0);
    idle(3);

    // Coins 5,5 then cancel; then cancel at zero credit.
    do_reset();
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    chk("cancel_chg_set", int'(chg_set), 1);
    chk("cancel_amount", int'(change_amount), 10);
    chk("cancel_no_disp", int'(disp_set), 0);
    idle(10);
    step(1'b0, 2'b00, 1'b1);
    chk("cancel0_chg_set", int'(chg_set), 0);
    chk("cancel0_busy", int'(busy), 0);

    // Coin strobed during D_HOLD.
    do_reset();
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    idle(3);
    step(1'b1, 2'b10, 1'b0);
    chk("dhold_reject", int'(coin_reject), 1);
    chk("dhold_credit", int'(credit), 0);
    idle(15);

    // Asynchronous reset while in C_HOLD.
    do_reset();
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    idle(3);
    #2 reset = 1'b1;
    #1;
    chk("areset_busy", int'(busy), 0);
    chk("areset_change", int'(change_amount), 0);
    chk("areset_pulses",
        int'(disp_set | disp_reset | chg_set | chg_reset), 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    check_cycle();
    step(1'b1, 2'b01, 1'b0);
    chk("areset_after_credit", int'(credit), 10);
    idle(3);

    // Dispense latch never acknowledges.
    m_on = 1'b0;
    d_stuck = 1'b1;
    do_reset();
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    chk("stuck_disp_set", int'(disp_set), 1);
    k = 0;
    while (!fault && k < 20) begin
      idle(1);
      k++;
    end
    chk("fault_latency", k, 8);
    chk("fault_disp_reset", int'(disp_reset), 1);
    chk("fault_chg_reset", int'(chg_reset), 1);
    chk("fault_no_set", int'(disp_set | chg_set), 0);
    chk("fault_credit", int'(credit), 0);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("fault_sticky", int'(fault), 1);
      chk("fault_quiet",
          int'(disp_set | disp_reset | chg_set | chg_reset), 0);
    end
    d_stuck = 1'b0;
    do_reset();
    chk("fault_cleared", int'(fault), 0);
    chk("fault_clr_busy", int'(busy), 0);

    // Overflow at MAX_CREDIT on the PRICE=40 instance.
    cv2 = 1'b1; val2 = 2'b10;
    @(negedge clock);
    chk("ovf_c25", int'(o2_credit), 25);
    chk("ovf_c25_rej", int'(o2_rej), 0);
    @(negedge clock);
    chk("ovf_credit", int'(o2_credit), 25);
    chk("ovf_reject", int'(o2_rej), 1);
    val2 = 2'b01;
    @(negedge clock);
    chk("ovf_c35", int'(o2_credit), 35);
    val2 = 2'b00;
    @(negedge clock);
    chk("ovf_c40", int'(o2_credit), 40);
    chk("ovf_c40_rej", int'(o2_rej), 0);
    cv2 = 1'b0;
    @(negedge clock);
    chk("ovf_disp_set", int'(o2_ds), 1);
    chk("ovf_credit0", int'(o2_credit), 0);

    // Random traffic against the timeline model.
    m_on = 1'b1;
    do_reset();
    repeat (2500) begin
      step(($urandom % 3) == 0, 2'($urandom_range(3, 0)),
           ($urandom % 16) == 0);
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
